mioc_gen: RTL and testbench

- Parametrised successor to the single-RAM/single-IO memory-IO controller.
- Sits between the MIPS core data port and the data RAM plus NUM_IO I/O peripheral channels.
- Adds a registered request FSM with a memReady stall handshake, configurable RAM latency, per-channel IO ready handshake with timeout, and a sticky bus-error flag for unmapped or hung accesses.

---
 rtl/mioc_gen.sv | 154 +++++++++++++++
 tb/tb_mioc_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_gen.sv
// Memory/IO controller between the CPU data port, the data RAM and NUM_IO IO channels.
// Registered request FSM with memReady stall handshake, IO timeout and sticky bus error.
module mioc_gen #(
  parameter int unsigned NUM_IO  = 4,
  parameter logic [3:0]  IO_PAGE = 4'hF,
  parameter int unsigned CH_LSB  = 8,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memCe,
  input  logic                   memWr,
  input  logic [31:0]            memAddr,
  input  logic [31:0]            wtData,
  output logic [31:0]            rdData,
  output logic                   memReady,
  output logic                   ramCe,
  output logic                   ramWe,
  output logic [31:0]            ramAddr,
  output logic [31:0]            ramWtData,
  input  logic [31:0]            ramRdData,
  output logic [NUM_IO-1:0]      ioCe,
  output logic                   ioWe,
  output logic [31:0]            ioAddr,
  output logic [31:0]            ioWtData,
  input  logic [32*NUM_IO-1:0]   ioRdData,
  input  logic [NUM_IO-1:0]      ioReady,
  output logic                   busErr,
  input  logic                   errClr
);

  localparam int unsigned MAX_WAIT = (RAM_LAT > TIMEOUT) ? RAM_LAT : TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, RAM, IO, ERR, DONE} stateT;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } reqT;

  stateT             state, nextState;
  reqT               req, reqD;
  logic [3:0]        ch, chD;
  logic [CNT_W-1:0]  cnt, cntD;
  logic [31:0]       rdDataD;
  logic              memReadyD, ramCeD, ramWeD, ioWeD, busErrD;
  logic [NUM_IO-1:0] ioCeD;
  logic              selReady;
  logic [31:0]       selRdData;

  assign ramAddr   = req.addr;
  assign ramWtData = req.data;
  assign ioAddr    = req.addr;
  assign ioWtData  = req.data;

  // Route the latched channel's handshake and read data; other channels are ignored.
  always_comb begin
    selReady  = 1'b0;
    selRdData = '0;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      if (ch == 4'(i)) begin
        selReady  = ioReady[i];
        selRdData = ioRdData[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req      <= '0;
      ch       <= '0;
      cnt      <= '0;
      rdData   <= '0;
      memReady <= 1'b0;
      ramCe    <= 1'b0;
      ramWe    <= 1'b0;
      ioCe     <= '0;
      ioWe     <= 1'b0;
      busErr   <= 1'b0;
    end else begin
      state    <= nextState;
      req      <= reqD;
      ch       <= chD;
      cnt      <= cntD;
      rdData   <= rdDataD;
      memReady <= memReadyD;
      ramCe    <= ramCeD;
      ramWe    <= ramWeD;
      ioCe     <= ioCeD;
      ioWe     <= ioWeD;
      busErr   <= busErrD;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    nextState = state;
    reqD      = req;
    chD       = ch;
    cntD      = cnt;
    rdDataD   = rdData;
    busErrD   = errClr ? 1'b0 : busErr;

    case (state)
      IDLE: begin
        if (memCe) begin
          reqD = '{wr: memWr, addr: memAddr, data: wtData};
          chD  = memAddr[CH_LSB +: 4];
          cntD = '0;
          if (memAddr[31:28] != IO_PAGE)
            nextState = RAM;
          else if (32'(memAddr[CH_LSB +: 4]) < NUM_IO)
            nextState = IO;
          else
            nextState = ERR;
        end
      end
      RAM: begin
        cntD = cnt + CNT_W'(1);
        if (cnt == CNT_W'(RAM_LAT - 1)) begin
          if (!req.wr) rdDataD = ramRdData;
          nextState = DONE;
        end
      end
      IO: begin
        cntD = cnt + CNT_W'(1);
        if (selReady) begin
          if (!req.wr) rdDataD = selRdData;
          nextState = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          nextState = ERR;
        end
      end
      ERR: begin
        rdDataD   = '0;
        busErrD   = 1'b1;
        nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase

    memReadyD = (nextState == DONE);
    ramCeD    = (nextState == RAM);
    ramWeD    = (nextState == RAM) && reqD.wr;
    ioCeD     = (nextState == IO) ? (NUM_IO'(1) << chD) : '0;
    ioWeD     = (nextState == IO) && reqD.wr;
  end

endmodule

// File: tb/tb_mioc_gen.sv
// Bench for mioc_gen: two instances (RAM_LAT 1 and 3) checked every cycle against a
// transaction-schedule model, plus directed literal pins.
module tb_mioc_gen;
  localparam int TMO  = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         memCe     [2];
  logic         memWr     [2];
  logic [31:0]  memAddr   [2];
  logic [31:0]  wtData    [2];
  logic [31:0]  rdData    [2];
  logic         memReady  [2];
  logic         ramCe     [2];
  logic         ramWe     [2];
  logic [31:0]  ramAddr   [2];
  logic [31:0]  ramWtData [2];
  logic [31:0]  ramRdData [2];
  logic [3:0]   ioCe      [2];
  logic         ioWe      [2];
  logic [31:0]  ioAddr    [2];
  logic [31:0]  ioWtData  [2];
  logic [127:0] ioRdData  [2];
  logic [3:0]   ioReady   [2];
  logic         busErr    [2];
  logic         errClr    [2];

  mioc_gen #(.NUM_IO(4), .IO_PAGE(4'hF), .CH_LSB(8), .RAM_LAT(LAT0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .memCe(memCe[0]), .memWr(memWr[0]), .memAddr(memAddr[0]),
    .wtData(wtData[0]), .rdData(rdData[0]), .memReady(memReady[0]), .ramCe(ramCe[0]),
    .ramWe(ramWe[0]), .ramAddr(ramAddr[0]), .ramWtData(ramWtData[0]), .ramRdData(ramRdData[0]),
    .ioCe(ioCe[0]), .ioWe(ioWe[0]), .ioAddr(ioAddr[0]), .ioWtData(ioWtData[0]),
    .ioRdData(ioRdData[0]), .ioReady(ioReady[0]), .busErr(busErr[0]), .errClr(errClr[0]));

  mioc_gen #(.NUM_IO(4), .IO_PAGE(4'hF), .CH_LSB(8), .RAM_LAT(LAT1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .memCe(memCe[1]), .memWr(memWr[1]), .memAddr(memAddr[1]),
    .wtData(wtData[1]), .rdData(rdData[1]), .memReady(memReady[1]), .ramCe(ramCe[1]),
    .ramWe(ramWe[1]), .ramAddr(ramAddr[1]), .ramWtData(ramWtData[1]), .ramRdData(ramRdData[1]),
    .ioCe(ioCe[1]), .ioWe(ioWe[1]), .ioAddr(ioAddr[1]), .ioWtData(ioWtData[1]),
    .ioRdData(ioRdData[1]), .ioReady(ioReady[1]), .busErr(busErr[1]), .errClr(errClr[1]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: one transaction per lane described by accept cycle, last active cycle and done cycle.
  int          mN [2], mEnd [2], mD [2], mKind [2];  // kind 0=RAM 1=IO 2=unmapped
  logic        mWr [2], mErr [2], expBusErr [2];
  logic [3:0]  mCh [2];
  logic [31:0] mAddr [2], mAddrPrev [2], mData [2], mDataPrev [2], mRdPrev [2], mRdNew [2];

  function automatic int lat(int l);
    return (l == 0) ? LAT0 : LAT1;
  endfunction

  function automatic void chk(string name, int l, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lane%0d cyc=%0d got=%h exp=%h", name, l, cyc, got, exp);
    end
  endfunction

  function automatic void resetModel(int l);
    mN[l] = -100; mEnd[l] = -100; mD[l] = -100; mKind[l] = 0;
    mWr[l] = 1'b0; mErr[l] = 1'b0; expBusErr[l] = 1'b0; mCh[l] = '0;
    mAddr[l] = '0; mAddrPrev[l] = '0; mData[l] = '0; mDataPrev[l] = '0;
    mRdPrev[l] = '0; mRdNew[l] = '0;
  endfunction

  // k = cycles after acceptance at which the selected ioReady rises; k outside 1..TMO never rises.
  function automatic void plan(int l, logic wr, logic [31:0] addr, logic [31:0] data,
                               logic [31:0] rdv, int k, int n);
    logic [3:0] c;
    c = addr[11:8];
    mAddrPrev[l] = mAddr[l]; mDataPrev[l] = mData[l]; mRdPrev[l] = mRdNew[l];
    mAddr[l] = addr; mData[l] = data; mWr[l] = wr; mCh[l] = c; mN[l] = n;
    mErr[l] = 1'b0; mRdNew[l] = mRdPrev[l];
    if (addr[31:28] != 4'hF) begin
      mKind[l] = 0; mEnd[l] = n + lat(l); mD[l] = mEnd[l] + 1;
      if (!wr) mRdNew[l] = rdv;
    end else if (c < 4'd4) begin
      mKind[l] = 1;
      if (k >= 1 && k <= TMO) begin
        mEnd[l] = n + k; mD[l] = mEnd[l] + 1;
        if (!wr) mRdNew[l] = rdv + 32'(c);
      end else begin
        mEnd[l] = n + TMO; mD[l] = n + TMO + 2; mRdNew[l] = '0; mErr[l] = 1'b1;
      end
    end else begin
      mKind[l] = 2; mEnd[l] = n; mD[l] = n + 2; mRdNew[l] = '0; mErr[l] = 1'b1;
    end
  endfunction

  function automatic logic clrPick(int mode, int off);
    return (mode == off) || (mode == -2 && $urandom_range(0, 7) == 0);
  endfunction

  task automatic driveReq(int l, logic wr, logic [31:0] addr, logic [31:0] data,
                          logic [31:0] rdv, int clrOff);
    memCe[l] = 1'b1; memWr[l] = wr; memAddr[l] = addr; wtData[l] = data;
    ramRdData[l] = rdv;
    for (int i = 0; i < 4; i++) ioRdData[l][32*i +: 32] = rdv + 32'(i);
    ioReady[l] = 4'($urandom);
    errClr[l]  = clrPick(clrOff, 0);
  endtask

  // Issue one request and drive the lane until its memReady cycle; clrOff -1 none, -2 random.
  task automatic tx(int l, logic wr, logic [31:0] addr, logic [31:0] data,
                    logic [31:0] rdv, int k, int clrOff);
    int n;
    logic [3:0] rdy;
    @(negedge clk);
    n = cyc;
    driveReq(l, wr, addr, data, rdv, clrOff);
    plan(l, wr, addr, data, rdv, k, n);
    for (int t = n + 1; t <= mD[l]; t++) begin
      @(negedge clk);
      memCe[l] = 1'($urandom); memWr[l] = 1'($urandom);
      memAddr[l] = $urandom; wtData[l] = $urandom;
      if (t > mEnd[l]) ramRdData[l] = $urandom;
      rdy = 4'($urandom);
      rdy[mCh[l]] = (mKind[l] == 1) && !mErr[l] && (t == mEnd[l]);
      ioReady[l] = rdy;
      errClr[l] = clrPick(clrOff, t - n);
    end
  endtask

  task automatic idle(int l, int n, int clrMode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      memCe[l] = 1'b0; memWr[l] = 1'($urandom); memAddr[l] = $urandom;
      ioReady[l] = 4'($urandom); errClr[l] = clrPick(clrMode, 1);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    logic        act;
    logic [31:0] eAddr, eData;
    #1;
    for (int l = 0; l < 2; l++) begin
      if (!rst) begin
        expBusErr[l] = 1'b0;
        chk("rstRdData", l, rdData[l], '0);
        chk("rstMemReady", l, 32'(memReady[l]), '0);
        chk("rstRamCe", l, 32'({ramCe[l], ramWe[l]}), '0);
        chk("rstIoCe", l, 32'({ioCe[l], ioWe[l]}), '0);
        chk("rstAddr", l, ramAddr[l] | ioAddr[l] | ramWtData[l] | ioWtData[l], '0);
        chk("rstBusErr", l, 32'(busErr[l]), '0);
      end else begin
        if (mErr[l] && cyc == mD[l]) expBusErr[l] = 1'b1;
        else if (errClr[l])          expBusErr[l] = 1'b0;
        act   = (cyc > mN[l]) && (cyc <= mEnd[l]);
        eAddr = (cyc > mN[l]) ? mAddr[l] : mAddrPrev[l];
        eData = (cyc > mN[l]) ? mData[l] : mDataPrev[l];
        chk("memReady", l, 32'(memReady[l]), 32'(cyc == mD[l]));
        chk("ramCe", l, 32'(ramCe[l]), 32'(act && mKind[l] == 0));
        chk("ramWe", l, 32'(ramWe[l]), 32'(act && mKind[l] == 0 && mWr[l]));
        chk("ioCe", l, 32'(ioCe[l]), (act && mKind[l] == 1) ? (32'd1 << mCh[l]) : 32'd0);
        chk("ioWe", l, 32'(ioWe[l]), 32'(act && mKind[l] == 1 && mWr[l]));
        chk("ramAddr", l, ramAddr[l], eAddr);
        chk("ioAddr", l, ioAddr[l], eAddr);
        chk("ramWtData", l, ramWtData[l], eData);
        chk("ioWtData", l, ioWtData[l], eData);
        chk("rdData", l, rdData[l], (cyc >= mD[l]) ? mRdNew[l] : mRdPrev[l]);
        chk("busErr", l, 32'(busErr[l]), 32'(expBusErr[l]));
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r, k;
    for (int l = 0; l < 2; l++) begin
      memCe[l] = 1'b0; memWr[l] = 1'b0; memAddr[l] = '0; wtData[l] = '0;
      ramRdData[l] = '0; ioRdData[l] = '0; ioReady[l] = '0; errClr[l] = 1'b0;
      resetModel(l);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Lane 0, RAM_LAT=1: directed pins.
    tx(0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, -1);
    chk("pinRamRd", 0, rdData[0], 32'h1234_5678);
    chk("pinRamReady", 0, 32'(memReady[0]), 32'd1);
    tx(0, 1'b0, 32'hF000_0500, 32'h0, 32'h5555_0000, 0, -1);
    chk("pinUnmapRd", 0, rdData[0], 32'h0);
    chk("pinUnmapErr", 0, 32'(busErr[0]), 32'd1);
    idle(0, 1, 1); idle(0, 1, 0);
    chk("pinErrClr", 0, 32'(busErr[0]), 32'd0);
    tx(0, 1'b0, 32'hF000_0200, 32'h0, 32'hA5A5_0000, 3, -1);
    chk("pinIoRd", 0, rdData[0], 32'hA5A5_0002);
    tx(0, 1'b0, 32'hF000_0100, 32'h0, 32'h7777_0000, 99, -1);
    chk("pinTmoRd", 0, rdData[0], 32'h0);
    chk("pinTmoErr", 0, 32'(busErr[0]), 32'd1);
    idle(0, 1, 1); idle(0, 1, 0);
    tx(0, 1'b0, 32'hF000_0300, 32'h0, 32'h0, 99, TMO + 1);
    idle(0, 1, 0);
    chk("pinSetWins", 0, 32'(busErr[0]), 32'd1);
    idle(0, 1, 1);
    tx(0, 1'b1, 32'hF000_0000, 32'hBEEF_0001, 32'h0, TMO, -1);
    idle(0, 2, -1);

    // Lane 1, RAM_LAT=3: write pin, reset mid-access, recovery.
    tx(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0, -1);
    chk("pinWrData", 1, ramWtData[1], 32'hCAFE_F00D);
    chk("pinWrReady", 1, 32'(memReady[1]), 32'd1);
    chk("pinWrErr", 1, 32'(busErr[1]), 32'd0);
    @(negedge clk);
    driveReq(1, 1'b0, 32'h0000_0080, 32'h0, 32'h1111_2222, -1);
    plan(1, 1'b0, 32'h0000_0080, 32'h0, 32'h1111_2222, 0, cyc);
    idle(1, 2, -1);
    rst = 1'b0;
    resetModel(0); resetModel(1);
    #1;
    chk("pinRstRamCe", 1, 32'(ramCe[1]), 32'd0);
    chk("pinRstAddr", 1, ramAddr[1], 32'h0);
    idle(1, 2, -1);
    rst = 1'b1;
    tx(1, 1'b0, 32'h0000_0084, 32'h0, 32'h3333_4444, 0, -1);
    chk("pinRecover", 1, rdData[1], 32'h3333_4444);
    idle(1, 1, -1);

    // Randomized traffic on both lanes.
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        k = 0;
        if (r < 5) begin
          a = {4'($urandom_range(0, 14)), 28'($urandom)};
        end else if (r < 8) begin
          a = {4'hF, 16'($urandom), 4'($urandom_range(0, 3)), 8'($urandom)};
          k = $urandom_range(1, 20);
        end else begin
          a = {4'hF, 16'($urandom), 4'($urandom_range(4, 15)), 8'($urandom)};
        end
        tx(l, 1'($urandom), a, $urandom, $urandom, k, -2);
        idle(l, $urandom_range(0, 2), -2);
      end
      idle(l, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
